// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - eight-channel DIP-switch debouncer with change pulse and popcount
//
// Purpose:
//   Each raw switch level is brought into the clk domain through a two-flop
//   synchronizer. A per-bit counter then measures how long the synchronized
//   level has disagreed with the debounced output; after DB_CYCLES consecutive
//   disagreeing samples the output bit takes the new level.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous active-high reset
//   switch_in   in   8  raw asynchronous switch levels
//   switch_out  out  8  debounced switch levels
//   sw_cnt      out  4  registered number of ones in switch_out
//   sw_chg      out  1  one-cycle pulse the cycle after switch_out updates
//
// Configuration:
//   SW_POPCOUNT_EN  defined   -> sw_cnt carries popcount(switch_out)
//                   undefined -> popcount logic removed, sw_cnt tied to 0

module switch_debounce #(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] switch_in,
  output logic [7:0] switch_out,
  output logic [3:0] sw_cnt,
  output logic       sw_chg
);

  localparam int            CW    = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(DB_CYCLES - 1);

  logic [7:0]    r_s1;
  logic [7:0]    r_s2;
  logic [7:0]    r_out;
  logic [7:0]    r_out_d;
  logic          r_chg;
  logic [CW-1:0] r_cnt [8];

  logic [7:0]    w_diff;
  logic [7:0]    w_load;

  always_comb begin
    w_diff = r_s2 ^ r_out;
    w_load = '0;
    for (int i = 0; i < 8; i++) begin
      w_load[i] = w_diff[i] && (r_cnt[i] == LIMIT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= switch_in;
      r_s2 <= r_s1;
    end
  end

  // Counter clears when the level agrees with the output or when it is
  // consumed by a load, so it never passes LIMIT.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (rst || !w_diff[i] || w_load[i]) begin
        r_cnt[i] <= '0;
      end else begin
        r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  // A load only happens when s2 differs from the output, so loading s2 is
  // the same as flipping that bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_out_d <= '0;
      r_chg   <= 1'b0;
    end else begin
      r_out   <= r_out ^ w_load;
      r_out_d <= r_out;
      r_chg   <= |(r_out ^ r_out_d);
    end
  end

  assign switch_out = r_out;
  assign sw_chg     = r_chg;

`ifdef SW_POPCOUNT_EN
  logic [3:0] r_pop;
  logic [3:0] w_pop;

  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'd0, r_out[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pop <= 4'd0;
    end else begin
      r_pop <= w_pop;
    end
  end

  assign sw_cnt = r_pop;
`else
  assign sw_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - self-checking bench for switch_debounce with a window-based reference model

module tb_switch_debounce;

  localparam int DB     = 16;
  localparam int MAXE   = 16384;
`ifdef SW_POPCOUNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] switch_in;
  logic [7:0] switch_out;
  logic [3:0] sw_cnt;
  logic       sw_chg;

  int checks   = 0;
  int failures = 0;

  switch_debounce #(.DB_CYCLES(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .switch_in  (switch_in),
    .switch_out (switch_out),
    .sw_cnt     (sw_cnt),
    .sw_chg     (sw_chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: an output bit flips at edge e when the DB most recent
  // synchronized samples (the input seen two edges earlier) all disagree with
  // it and no reset or earlier flip of that bit lies inside that window.
  bit         rst_at    [MAXE];
  logic [7:0] in_at     [MAXE];
  logic [7:0] hist      [MAXE];
  logic [7:0] out_after [MAXE];
  int         last_ev   [8];
  int         e = 0;
  logic [7:0] m_out = 8'h00;
  logic [7:0] exp_out = 8'h00;
  logic [3:0] exp_cnt = 4'd0;
  logic       exp_chg = 1'b0;

  always @(posedge clk) begin
    bit ok;
    e = e + 1;
    rst_at[e] = rst;
    in_at[e]  = switch_in;
    hist[e]   = (e >= 3 && !rst_at[e-1] && !rst_at[e-2]) ? in_at[e-2] : 8'h00;
    if (rst) begin
      m_out = 8'h00;
      for (int i = 0; i < 8; i++) last_ev[i] = e;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (e - last_ev[i] >= DB) begin
          ok = 1'b1;
          for (int j = e - DB + 1; j <= e; j++) begin
            if (hist[j][i] == m_out[i]) ok = 1'b0;
          end
          if (ok) begin
            m_out[i]   = ~m_out[i];
            last_ev[i] = e;
          end
        end
      end
    end
    out_after[e] = m_out;
    exp_out = m_out;
    if (rst || e < 2) exp_cnt = 4'd0;
    else              exp_cnt = 4'(CNT_ON * $countones(out_after[e-1]));
    if (rst || e < 3) exp_chg = 1'b0;
    else              exp_chg = (out_after[e-1] != out_after[e-2]) && !rst_at[e-1];
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    switch_in = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (switch_out !== 8'h00 || sw_cnt !== 4'd0 || sw_chg !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got out=%h cnt=%0d chg=%b want 00/0/0", c, switch_out, sw_cnt, sw_chg);
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks++;
      if (switch_out !== exp_out || sw_cnt !== exp_cnt || sw_chg !== exp_chg) begin
        failures++;
        $display("FAIL reset_release_model cyc=%0d got %h/%0d/%b want %h/%0d/%b", c, switch_out, sw_cnt, sw_chg, exp_out, exp_cnt, exp_chg);
      end
      if (c == 17) begin
        checks++;
        if (switch_out !== 8'h00) begin
          failures++;
          $display("FAIL reset_release_early got %h want 00", switch_out);
        end
      end
      if (c == 18) begin
        checks++;
        if (switch_out !== 8'hFF || sw_chg !== 1'b0) begin
          failures++;
          $display("FAIL reset_release_load got out=%h chg=%b want FF/0", switch_out, sw_chg);
        end
      end
      if (c == 19) begin
        checks++;
        if (sw_chg !== 1'b1 || sw_cnt !== 4'(8 * CNT_ON)) begin
          failures++;
          $display("FAIL reset_release_pulse got chg=%b cnt=%0d want 1/%0d", sw_chg, sw_cnt, 8 * CNT_ON);
        end
      end
      if (c == 20) begin
        checks++;
        if (sw_chg !== 1'b0) begin
          failures++;
          $display("FAIL reset_release_pulse_width got chg=%b want 0", sw_chg);
        end
      end
    end
  endtask

  task automatic settle(input logic [7:0] v);
    switch_in = v;
    for (int c = 0; c < 25; c++) begin
      step();
      checks++;
      if (switch_out !== exp_out || sw_cnt !== exp_cnt || sw_chg !== exp_chg) begin
        failures++;
        $display("FAIL settle_model v=%h cyc=%0d got %h/%0d/%b want %h/%0d/%b", v, c, switch_out, sw_cnt, sw_chg, exp_out, exp_cnt, exp_chg);
      end
    end
  endtask

  task automatic test_clean_change();
    int pulses = 0;
    settle(8'h00);
    switch_in = 8'h1F;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (sw_chg === 1'b1) pulses++;
      checks++;
      if (switch_out !== exp_out || sw_cnt !== exp_cnt || sw_chg !== exp_chg) begin
        failures++;
        $display("FAIL clean_model cyc=%0d got %h/%0d/%b want %h/%0d/%b", c, switch_out, sw_cnt, sw_chg, exp_out, exp_cnt, exp_chg);
      end
      if (c == 17 || c == 18) begin
        checks++;
        if (switch_out !== (c == 17 ? 8'h00 : 8'h1F)) begin
          failures++;
          $display("FAIL clean_latency cyc=%0d got %h", c, switch_out);
        end
      end
      if (c == 19) begin
        checks++;
        if (sw_cnt !== 4'(5 * CNT_ON) || sw_chg !== 1'b1) begin
          failures++;
          $display("FAIL clean_cnt got cnt=%0d chg=%b want %0d/1", sw_cnt, sw_chg, 5 * CNT_ON);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL clean_pulse_count got %0d want 1", pulses);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    settle(8'h00);
    for (int r = 0; r < 5; r++) begin
      for (int h = 0; h < 20; h++) begin
        switch_in = (h < 10) ? 8'h01 : 8'h00;
        step();
        if (sw_chg === 1'b1) pulses++;
        checks++;
        if (switch_out !== 8'h00 || switch_out !== exp_out || sw_cnt !== exp_cnt || sw_chg !== exp_chg) begin
          failures++;
          $display("FAIL glitch rep=%0d h=%0d got %h/%0d/%b want 00/%0d/%b", r, h, switch_out, sw_cnt, sw_chg, exp_cnt, exp_chg);
        end
      end
    end
    checks++;
    if (pulses != 0 || sw_cnt !== 4'd0) begin
      failures++;
      $display("FAIL glitch_summary got pulses=%0d cnt=%0d want 0/0", pulses, sw_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int pulses = 0;
    settle(8'h00);
    switch_in = 8'hE0;
    step();
    switch_in = 8'hE2;
    for (int c = 2; c <= 25; c++) begin
      step();
      if (sw_chg === 1'b1) begin
        if (first < 0) first = c;
        pulses++;
      end
      checks++;
      if (switch_out !== exp_out || sw_cnt !== exp_cnt || sw_chg !== exp_chg) begin
        failures++;
        $display("FAIL b2b_model cyc=%0d got %h/%0d/%b want %h/%0d/%b", c, switch_out, sw_cnt, sw_chg, exp_out, exp_cnt, exp_chg);
      end
    end
    checks++;
    if (pulses != 2 || first != 19) begin
      failures++;
      $display("FAIL b2b_pulses got n=%0d first=%0d want 2/19", pulses, first);
    end
    checks++;
    if (switch_out !== 8'hE2 || sw_cnt !== 4'(4 * CNT_ON)) begin
      failures++;
      $display("FAIL b2b_final got %h/%0d want E2/%0d", switch_out, sw_cnt, 4 * CNT_ON);
    end
  endtask

  task automatic test_reset_mid_count();
    settle(8'h00);
    switch_in = 8'hFE;
    repeat (10) step();
    rst = 1'b1;
    step();
    checks++;
    if (switch_out !== 8'h00 || sw_chg !== 1'b0 || sw_cnt !== 4'd0) begin
      failures++;
      $display("FAIL midrst_during got %h/%0d/%b want 00/0/0", switch_out, sw_cnt, sw_chg);
    end
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks++;
      if (switch_out !== exp_out || sw_cnt !== exp_cnt || sw_chg !== exp_chg) begin
        failures++;
        $display("FAIL midrst_model cyc=%0d got %h/%0d/%b want %h/%0d/%b", c, switch_out, sw_cnt, sw_chg, exp_out, exp_cnt, exp_chg);
      end
      if (c <= 18) begin
        checks++;
        if (switch_out !== (c < 18 ? 8'h00 : 8'hFE)) begin
          failures++;
          $display("FAIL midrst_latency cyc=%0d got %h", c, switch_out);
        end
      end
      if (c == 19) begin
        checks++;
        if (sw_cnt !== 4'(7 * CNT_ON) || sw_chg !== 1'b1) begin
          failures++;
          $display("FAIL midrst_cnt got %0d/%b want %0d/1", sw_cnt, sw_chg, 7 * CNT_ON);
        end
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int s = 0; s < 200; s++) begin
      int hold;
      hold = $urandom_range(1, 24);
      switch_in = 8'($urandom);
      rst = ($urandom_range(0, 24) == 0);
      for (int h = 0; h < hold; h++) begin
        step();
        rst = 1'b0;
        checks++;
        if (switch_out !== exp_out || sw_cnt !== exp_cnt || sw_chg !== exp_chg) begin
          failures++;
          bad++;
          if (bad < 20)
            $display("FAIL random seg=%0d h=%0d got %h/%0d/%b want %h/%0d/%b", s, h, switch_out, sw_cnt, sw_chg, exp_out, exp_cnt, exp_chg);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    switch_in = 8'h00;
    test_reset();
    test_clean_change();
    test_glitch();
    test_back_to_back();
    test_reset_mid_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
